reg_master: RTL and testbench
=============================

// Module: reg_master
// PURPOSE
//   Initiator for the regs register-access interface (req/rd_wr/addr/write_val -> ack/read_val).
//   Accepts read/write commands on a valid/ready port, issues them to the regs block one at a time,
//   and returns one response per command (read data, or a timeout error).
//   Sits between a CPU/sequencer-side command source and the regs block.
// PARAMETERS
//   ADDR_W    4             register address width
//   DATA_W    32            data width
//   TIMEOUT   16            read: max cycles waiting for ack before error (>=2)
//   ERR_DATA  32'hDEAD_BEEF rsp_rdata returned on a read timeout
// PORTS
//   clk        in   1       clock; all logic on posedge
//   reset      in   1       asynchronous, active-high reset
//   cmd_valid  in   1       command present
//   cmd_ready  out  1       master can accept a command (high only in IDLE)
//   cmd_rd_wr  in   1       1=read, 0=write
//   cmd_addr   in   ADDR_W  register address
//   cmd_wdata  in   DATA_W  write data (ignored for reads)
//   rsp_valid  out  1       response present; held until rsp_ready
//   rsp_ready  in   1       response consumer ready
//   rsp_rd_wr  out  1       echo of command type
//   rsp_rdata  out  DATA_W  read data; 0 for writes; ERR_DATA on timeout
//   rsp_err    out  1       1 = read timed out
//   req        out  1       to regs: one-cycle request pulse
//   rd_wr      out  1       to regs: 1=read, 0=write
//   addr       out  ADDR_W  to regs: address
//   write_val  out  DATA_W  to regs: write data
//   ack        in   1       from regs: read complete
//   read_val   in   DATA_W  from regs: read data, valid when ack=1
//   stray_ack  out  1       sticky: ack seen while no read outstanding
// BEHAVIOUR
//   - Reset (async): state IDLE; every output 0 except cmd_ready=1; counter 0. Reset mid-
//     transaction aborts it; no response is produced.
//   - States: IDLE -> REQ -> (read: WAIT_ACK | write: RESP) ; WAIT_ACK -> RESP ; RESP -> IDLE.
//   - IDLE: cmd_ready=1; on cmd_valid&&cmd_ready capture rd_wr/addr/wdata into rd_wr/addr/write_val
//     (write_val forced 0 for reads); go to REQ.
//   - REQ: req=1 for exactly this cycle. addr/rd_wr/write_val stay stable from REQ until return
//     to IDLE. Write -> RESP with rsp_rdata=0, rsp_err=0 (writes are posted, no ack awaited).
//   - WAIT_ACK: counter starts at 0 in the first WAIT_ACK cycle, +1 per cycle. ack=1 -> capture
//     read_val into rsp_rdata, rsp_err=0, go RESP. If counter==TIMEOUT-1 and ack=0 -> rsp_rdata=
//     ERR_DATA, rsp_err=1, go RESP. ack wins over timeout in the same cycle.
//   - RESP: rsp_valid=1, rsp_* stable; on rsp_ready -> IDLE (cmd_ready=1 next cycle). No bypass:
//     back-to-back commands are spaced by the RESP->IDLE cycle.
//   - Latency (rsp_ready=1): write accept@t, req@t+1, rsp_valid@t+2, next accept@t+3.
//     Read with ack sampled @t+2+k: rsp_valid@t+3+k.
//   - ack sampled only in WAIT_ACK; ack in any other state sets stray_ack (cleared by reset only)
//     and is otherwise ignored.
//   - Counter width $clog2(TIMEOUT+1); saturates, never wraps.
// STRUCTURE
//   - reg_master_pkg: state enum (IDLE,REQ,WAIT_ACK,RESP), RD=1'b1/WR=1'b0 constants.
//   - Sub-module reg_timeout_cnt: clear/enable counter with 'expired' flag at TIMEOUT-1.
//   - Top: FSM, captured command regs, response regs.
// TESTING (bench instantiates reg_master + regs, or an ack-model)
//   1 Reset: assert reset mid-read -> all outputs 0, cmd_ready=1, no rsp_valid after release.
//   2 Write addr=0 data=32'hFFFF_FFFF -> single req pulse, rd_wr=0, rsp_valid 2 cycles after
//     accept, rsp_rdata=0, rsp_err=0.
//   3 Read, model acks 3 cycles after req with 32'h1234_5678 -> rsp_rdata=32'h1234_5678, err=0.
//   4 Read, model never acks, TIMEOUT=16 -> rsp_valid after 16 WAIT_ACK cycles, rsp_err=1,
//     rsp_rdata=ERR_DATA; ack on final cycle instead -> err=0, data captured.
//   5 Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0, no second req.
//   6 Stray ack while IDLE -> stray_ack=1 and stays 1; no response generated.

Source files
------------

// File: rtl/reg_master_pkg.sv
// Shared types and constants for the regs-interface initiator.
package reg_master_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2,
    RESP     = 2'd3
  } state_e;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

endpackage

// File: rtl/reg_master_if.sv
// Command/response port plus the regs-side bus of reg_master.
interface reg_master_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_rd_wr;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              req;
  logic              rd_wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_val;
  logic              ack;
  logic [DATA_W-1:0] read_val;
  logic              stray_ack;

  modport master (
    input  cmd_valid, cmd_rd_wr, cmd_addr, cmd_wdata, rsp_ready, ack, read_val,
    output cmd_ready, rsp_valid, rsp_rd_wr, rsp_rdata, rsp_err,
           req, rd_wr, addr, write_val, stray_ack
  );

  modport slave (
    output cmd_valid, cmd_rd_wr, cmd_addr, cmd_wdata, rsp_ready, ack, read_val,
    input  cmd_ready, rsp_valid, rsp_rd_wr, rsp_rdata, rsp_err,
           req, rd_wr, addr, write_val, stray_ack
  );
endinterface

// File: rtl/reg_timeout_cnt.sv
// Saturating wait counter; expired_o flags the last permitted ack cycle.
module reg_timeout_cnt
  import reg_master_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != CW'(TIMEOUT)))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/reg_master.sv
// Single-outstanding initiator: command in, one req pulse to regs, one response out.
module reg_master
  import reg_master_pkg::*;
#(
  parameter int              ADDR_W   = 4,
  parameter int              DATA_W   = 32,
  parameter int              TIMEOUT  = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic          clk,
  input  logic          reset,
  reg_master_if.master  bus
);
  state_e            state_q, state_d;
  logic              rd_wr_q, rd_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              stray_q, stray_d;
  logic              expired;

  reg_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk       (clk),
    .rst       (reset),
    .clr_i     (state_q != WAIT_ACK),
    .en_i      (state_q == WAIT_ACK),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    rd_wr_d = rd_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          rd_wr_d = bus.cmd_rd_wr;
          addr_d  = bus.cmd_addr;
          wdata_d = (bus.cmd_rd_wr == RD) ? '0 : bus.cmd_wdata;
          state_d = REQ;
        end
      end
      REQ: begin
        if (rd_wr_q == RD) begin
          state_d = WAIT_ACK;
        end else begin
          // writes are posted: respond without waiting for ack
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      WAIT_ACK: begin
        if (bus.ack) begin
          rdata_d = bus.read_val;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (expired) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stray_d = stray_q | (bus.ack && (state_q != WAIT_ACK));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rd_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_wr_q <= rd_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      stray_q <= stray_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rd_wr = rd_wr_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.req       = (state_q == REQ);
  assign bus.rd_wr     = rd_wr_q;
  assign bus.addr      = addr_q;
  assign bus.write_val = wdata_q;
  assign bus.stray_ack = stray_q;

endmodule

// File: tb/tb_reg_master.sv
// Self-checking bench: the bench plays the regs block (a register array) and predicts responses.
module tb_reg_master;
  localparam int          ADDR_W   = 4;
  localparam int          DATA_W   = 32;
  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reg_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  reg_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // dly: ack arrives dly cycles after the req cycle; values outside 1..TIMEOUT mean no ack
  task automatic do_txn(input logic rd, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                        input int dly, input int hold);
    logic [DATA_W-1:0] exp_d;
    logic              exp_e;
    int                exp_lat, n, reqs, req_at, rsp_at, held;
    bit                done, acks;
    acks = rd && (dly >= 1) && (dly <= TIMEOUT);
    if (!rd) begin
      exp_d = '0; exp_e = 1'b0; exp_lat = 2;
    end else if (acks) begin
      exp_d = mem[a]; exp_e = 1'b0; exp_lat = 2 + dly;
    end else begin
      exp_d = ERR_DATA; exp_e = 1'b1; exp_lat = 2 + TIMEOUT;
    end
    chk("cmd_ready_before", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1; bus.cmd_rd_wr = rd; bus.cmd_addr = a; bus.cmd_wdata = wd;
    bus.rsp_ready = 1'b0;
    step();
    bus.cmd_valid = 1'b0; bus.cmd_wdata = $urandom; bus.cmd_addr = ADDR_W'($urandom);
    n = 1; reqs = 0; req_at = 0; rsp_at = 0; held = 0; done = 0;
    while (!done && n < 40) begin
      bus.ack      = acks && (n == 1 + dly);
      bus.read_val = bus.ack ? mem[a] : $urandom;
      if (bus.req) begin
        reqs++;
        req_at = n;
        chk("req_rd_wr", 64'(bus.rd_wr), 64'(rd));
        chk("req_addr", 64'(bus.addr), 64'(a));
        chk("req_wval", 64'(bus.write_val), rd ? 64'd0 : 64'(wd));
        if (!bus.rd_wr) mem[bus.addr] = bus.write_val;
      end
      if (bus.rsp_valid) begin
        if (rsp_at == 0) begin
          rsp_at = n;
          chk("rsp_latency", 64'(n), 64'(exp_lat));
          chk("rsp_rd_wr", 64'(bus.rsp_rd_wr), 64'(rd));
        end
        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_d));
        chk("rsp_err", 64'(bus.rsp_err), 64'(exp_e));
        chk("cmd_ready_busy", 64'(bus.cmd_ready), 64'd0);
        if (held < hold) begin
          bus.rsp_ready = 1'b0;
          held++;
        end else begin
          bus.rsp_ready = 1'b1;
          done = 1;
        end
      end
      step();
      n++;
    end
    bus.ack = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("rsp_completed", 64'(done), 64'd1);
    chk("req_count", 64'(reqs), 64'd1);
    chk("req_cycle", 64'(req_at), 64'd1);
    chk("back_to_idle", 64'({bus.cmd_ready, bus.rsp_valid}), 64'b10);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, 64'({bus.cmd_ready, bus.rsp_valid, bus.rsp_rd_wr, bus.rsp_err,
                             bus.req, bus.rd_wr, bus.stray_ack, bus.addr}), 64'(11'b100_0000_0000));
    chk({tag, "_rdata"}, 64'(bus.rsp_rdata), 64'd0);
    chk({tag, "_wval"}, 64'(bus.write_val), 64'd0);
  endtask

  initial begin
    int rsp_seen;
    bus.cmd_valid = 0; bus.cmd_rd_wr = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 0; bus.ack = 0; bus.read_val = '0;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;

    #2;
    chk_reset_outs("reset_in");
    step(); step();
    reset = 1'b0;
    step();
    chk_reset_outs("reset_out");

    // posted write of all-ones, then read-back with a 3-cycle ack
    do_txn(1'b0, 4'd0, 32'hFFFF_FFFF, 0, 0);
    do_txn(1'b0, 4'd3, 32'h1234_5678, 0, 0);
    do_txn(1'b1, 4'd3, '0, 3, 0);
    // timeout, then ack on the last permitted cycle
    do_txn(1'b1, 4'd3, '0, 99, 0);
    do_txn(1'b1, 4'd0, '0, TIMEOUT, 0);
    // backpressure on both kinds
    do_txn(1'b0, 4'd7, 32'hA5A5_0F0F, 0, 5);
    do_txn(1'b1, 4'd7, '0, 1, 5);
    do_txn(1'b1, 4'd9, '0, 99, 2);

    for (int i = 0; i < 40; i++)
      do_txn(1'($urandom), ADDR_W'($urandom), $urandom,
             int'($urandom_range(1, TIMEOUT + 3)), int'($urandom_range(0, 3)));

    chk("no_stray_yet", 64'(bus.stray_ack), 64'd0);

    // stray ack while idle: sticky flag, no response
    bus.ack = 1'b1; bus.read_val = 32'h0BAD_0BAD;
    step();
    bus.ack = 1'b0;
    rsp_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid) rsp_seen++;
      step();
    end
    chk("stray_set", 64'(bus.stray_ack), 64'd1);
    chk("stray_no_rsp", 64'(rsp_seen), 64'd0);
    chk("stray_idle", 64'(bus.cmd_ready), 64'd1);

    // reset in the middle of a read aborts it
    bus.cmd_valid = 1'b1; bus.cmd_rd_wr = 1'b1; bus.cmd_addr = 4'd5;
    step();
    bus.cmd_valid = 1'b0;
    step(); step(); step();
    chk("mid_read_busy", 64'(bus.cmd_ready), 64'd0);
    reset = 1'b1;
    #1;
    chk_reset_outs("mid_reset");
    step();
    reset = 1'b0;
    rsp_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid || bus.req) rsp_seen++;
      step();
    end
    chk("after_reset_quiet", 64'(rsp_seen), 64'd0);
    chk("after_reset_ready", 64'(bus.cmd_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
